// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - two-port (fetch/data) arbiter onto one memory port; optional ARB_PERF_CNT_EN conflict counter
module mips_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    input  logic        inst_req_valid,
    output logic        inst_req_ack,
    output logic [31:0] inst_rdata,
    output logic        inst_valid,
    input  logic        inst_ack,
    input  logic [31:0] data_addr,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_strb,
    output logic        data_req_ack,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    input  logic        data_rack,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_req_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_rack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] conflict_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;

    logic inst_pending;
    logic data_pending;

    assign inst_pending = inst_req_valid;
    assign data_pending = data_read | data_write;

    // State and latched request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_INST;
            last_grant_q <= OWN_DATA;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
        end
    end

    // Arbitration, request latching, memory drive and response routing
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        inst_req_ack = 1'b0;
        data_req_ack = 1'b0;
        inst_rdata   = '0;
        inst_valid   = 1'b0;
        data_rdata   = '0;
        data_rvalid  = 1'b0;
        mem_addr     = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = '0;
        mem_strb     = '0;
        mem_rack     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Acks are combinational, so gate them while reset holds the FSM
                if (!rst) begin
                    if (inst_pending && (!data_pending || last_grant_q == OWN_DATA)) begin
                        inst_req_ack = 1'b1;
                        addr_d       = inst_addr;
                        rd_d         = 1'b1;
                        wr_d         = 1'b0;
                        wdata_d      = '0;
                        strb_d       = '0;
                        owner_d      = OWN_INST;
                        last_grant_d = OWN_INST;
                        state_d      = S_REQ;
                    end else if (data_pending) begin
                        // A simultaneous read+write is resolved as a store
                        data_req_ack = 1'b1;
                        addr_d       = data_addr;
                        rd_d         = ~data_write;
                        wr_d         = data_write;
                        wdata_d      = data_wdata;
                        strb_d       = data_strb;
                        owner_d      = OWN_DATA;
                        last_grant_d = OWN_DATA;
                        state_d      = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_addr  = addr_q;
                mem_read  = rd_q;
                mem_write = wr_q;
                mem_wdata = wdata_q;
                mem_strb  = strb_q;
                if (mem_req_ack) begin
                    state_d = wr_q ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (owner_q == OWN_INST) begin
                    inst_valid = mem_rvalid;
                    inst_rdata = mem_rdata;
                    mem_rack   = inst_ack;
                end else begin
                    data_rvalid = mem_rvalid;
                    data_rdata  = mem_rdata;
                    mem_rack    = data_rack;
                end
                if (mem_rvalid && mem_rack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;

    // Count idle cycles where both requesters compete; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else if (state_q == S_IDLE && inst_pending && data_pending) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed and randomized check of mips_mem_arbiter against a transaction-level model
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_req_valid;
    logic        inst_req_ack;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        inst_ack;
    logic [31:0] data_addr;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_wdata;
    logic [3:0]  data_strb;
    logic        data_req_ack;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        data_rack;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_req_ack;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rack;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
`endif

    always #5 clk = ~clk;

    mips_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ack(inst_req_ack),
        .inst_rdata(inst_rdata), .inst_valid(inst_valid), .inst_ack(inst_ack),
        .data_addr(data_addr), .data_read(data_read), .data_write(data_write),
        .data_wdata(data_wdata), .data_strb(data_strb), .data_req_ack(data_req_ack),
        .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rack(data_rack),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_req_ack(mem_req_ack),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rack(mem_rack)
`ifdef ARB_PERF_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction record plus fairness bit
    bit          m_busy = 0;
    bit          m_sent = 0;
    bit          m_last_data = 1;
    bit          m_own_data = 0;
    bit          m_wr = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_strb = '0;
    logic [31:0] m_cnt = '0;
    bit          s_iack = 0;
    bit          s_dack = 0;

    always @(negedge clk) begin : compare
        logic [31:0] e_ir, e_dr, e_ma, e_mw, e_cnt;
        logic [3:0]  e_ms;
        logic        e_iack, e_dack, e_iv, e_dv, e_rd, e_wr, e_rack;
        logic        ir, dr, gi, gd;
        e_ir = '0; e_dr = '0; e_ma = '0; e_mw = '0; e_ms = '0;
        e_iack = 0; e_dack = 0; e_iv = 0; e_dv = 0; e_rd = 0; e_wr = 0; e_rack = 0;
        e_cnt = rst ? 32'd0 : m_cnt;
        ir = inst_req_valid;
        dr = data_read | data_write;
        if (rst) begin
            m_busy = 0; m_sent = 0; m_last_data = 1; m_cnt = '0;
        end else if (!m_busy) begin
            if (ir && dr) m_cnt = m_cnt + 32'd1;
            gd = dr && (!ir || !m_last_data);
            gi = ir && !gd;
            if (gi) begin
                e_iack = 1;
                m_addr = inst_addr; m_wr = 0; m_wdata = '0; m_strb = '0;
                m_own_data = 0; m_last_data = 0; m_busy = 1; m_sent = 0;
            end
            if (gd) begin
                e_dack = 1;
                m_addr = data_addr; m_wr = data_write; m_wdata = data_wdata; m_strb = data_strb;
                m_own_data = 1; m_last_data = 1; m_busy = 1; m_sent = 0;
            end
        end else if (!m_sent) begin
            e_ma = m_addr; e_rd = !m_wr; e_wr = m_wr; e_mw = m_wdata; e_ms = m_strb;
            if (mem_req_ack) begin
                if (m_wr) m_busy = 0;
                else m_sent = 1;
            end
        end else begin
            e_rack = m_own_data ? data_rack : inst_ack;
            if (m_own_data) begin e_dv = mem_rvalid; e_dr = mem_rdata; end
            else begin e_iv = mem_rvalid; e_ir = mem_rdata; end
            if (mem_rvalid && e_rack) m_busy = 0;
        end
        chk("inst_req_ack", inst_req_ack, e_iack);
        chk("data_req_ack", data_req_ack, e_dack);
        chk("inst_valid", inst_valid, e_iv);
        chk("inst_rdata", inst_rdata, e_ir);
        chk("data_rvalid", data_rvalid, e_dv);
        chk("data_rdata", data_rdata, e_dr);
        chk("mem_addr", mem_addr, e_ma);
        chk("mem_read", mem_read, e_rd);
        chk("mem_write", mem_write, e_wr);
        chk("mem_wdata", mem_wdata, e_mw);
        chk("mem_strb", mem_strb, e_ms);
        chk("mem_rack", mem_rack, e_rack);
        chk("rd_wr_exclusive", mem_read & mem_write, 1'b0);
`ifdef ARB_PERF_CNT_EN
        chk("conflict_cnt", conflict_cnt, e_cnt);
`endif
        s_iack = inst_req_ack;
        s_dack = data_req_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_addr = '0; inst_req_valid = 0; inst_ack = 0;
        data_addr = '0; data_read = 0; data_write = 0; data_wdata = '0; data_strb = '0; data_rack = 0;
        mem_req_ack = 0; mem_rdata = '0; mem_rvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        inst_addr = a; inst_req_valid = 1;
        #1 chk("fetch_grant", inst_req_ack, 1'b1);
        tick();
        inst_req_valid = 0;
        #1 chk("fetch_mem_read", mem_read, 1'b1);
        chk("fetch_mem_addr", mem_addr, a);
        mem_req_ack = 1;
        tick();
        mem_req_ack = 0; mem_rvalid = 1; mem_rdata = d; inst_ack = 1;
        #1 chk("fetch_valid", inst_valid, 1'b1);
        chk("fetch_rdata", inst_rdata, d);
        chk("fetch_rack", mem_rack, 1'b1);
        tick();
        mem_rvalid = 0; inst_ack = 0;
        #1 chk("fetch_idle", mem_read | inst_valid, 1'b0);
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        inst_req_valid = 1; data_read = 1;
        #1 chk("reset_iack", inst_req_ack, 1'b0);
        chk("reset_dack", data_req_ack, 1'b0);
        chk("reset_mem_read", mem_read, 1'b0);
        tick();
        tick();
        clear_inputs();
        rst = 0;

        // single fetch
        tick();
        do_fetch(32'h100, 32'h2408000A);

        // contention after reset: fetch wins, load follows
        do_reset();
        tick();
        inst_addr = 32'h104; inst_req_valid = 1; data_addr = 32'h2000; data_read = 1;
        #1 chk("both_iack", inst_req_ack, 1'b1);
        chk("both_dack", data_req_ack, 1'b0);
        tick();
        inst_req_valid = 0;
        #1 chk("both_mem_addr_i", mem_addr, 32'h104);
        chk("both_hold_dack", data_req_ack, 1'b0);
        mem_req_ack = 1;
        tick();
        mem_req_ack = 0; mem_rvalid = 1; mem_rdata = 32'h11112222; inst_ack = 1;
        #1 chk("both_inst_valid", inst_valid, 1'b1);
        chk("both_no_dvalid", data_rvalid, 1'b0);
        tick();
        mem_rvalid = 0; inst_ack = 0;
        #1 chk("both_dack_later", data_req_ack, 1'b1);
        tick();
        data_read = 0;
        #1 chk("load_mem_addr", mem_addr, 32'h2000);
        chk("load_mem_read", mem_read, 1'b1);
`ifdef ARB_PERF_CNT_EN
        chk("conflict_cnt_one", conflict_cnt, 32'd1);
`endif
        mem_req_ack = 1;
        tick();
        mem_req_ack = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; data_rack = 1;
        #1 chk("load_dvalid", data_rvalid, 1'b1);
        chk("load_rdata", data_rdata, 32'hCAFEF00D);
        chk("load_no_ivalid", inst_valid, 1'b0);
        tick();
        clear_inputs();

        // store with a 5-cycle stall while a fetch waits
        data_write = 1; data_addr = 32'h3000; data_wdata = 32'hDEADBEEF; data_strb = 4'h3;
        #1 chk("store_grant", data_req_ack, 1'b1);
        tick();
        data_write = 0; inst_addr = 32'h500; inst_req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_mem_write", mem_write, 1'b1);
            chk("stall_mem_addr", mem_addr, 32'h3000);
            chk("stall_mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk("stall_mem_strb", mem_strb, 4'h3);
            chk("stall_mem_read", mem_read, 1'b0);
            chk("stall_no_iack", inst_req_ack, 1'b0);
            if (i < 4) tick();
        end
        mem_req_ack = 1;
        #1 chk("store_no_dvalid", data_rvalid, 1'b0);
        tick();
        mem_req_ack = 0;
        #1 chk("after_store_iack", inst_req_ack, 1'b1);
        chk("after_store_idle", mem_write, 1'b0);
        tick();
        inst_req_valid = 0; mem_req_ack = 1;
        tick();
        mem_req_ack = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0500; inst_ack = 1;
        #1 chk("waited_fetch_valid", inst_valid, 1'b1);
        tick();
        clear_inputs();

        // reset while a load response is pending
        data_read = 1; data_addr = 32'h4000;
        tick();
        data_read = 0; mem_req_ack = 1;
        tick();
        mem_req_ack = 0;
        #1 chk("resp_wait_rack", mem_rack, 1'b0);
        rst = 1; mem_rvalid = 1; data_rack = 1; mem_rdata = 32'h55AA55AA;
        #1 chk("rst_dvalid", data_rvalid, 1'b0);
        chk("rst_rdata", data_rdata, 32'h0);
        chk("rst_rack", mem_rack, 1'b0);
        tick();
        rst = 0;
        clear_inputs();
        tick();
        do_fetch(32'h200, 32'h12345678);

        // randomized traffic with occasional reset pulses
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (inst_req_valid && s_iack) inst_req_valid = 0;
            else if (!inst_req_valid && $urandom_range(0, 2) == 0) begin
                inst_req_valid = 1;
                inst_addr = {$urandom(), 2'b00} >> 2 << 2;
            end
            if ((data_read || data_write) && s_dack) begin
                data_read = 0; data_write = 0;
            end else if (!(data_read || data_write) && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: begin data_read = 1; data_write = 0; end
                    2: begin data_read = 0; data_write = 1; end
                    default: begin data_read = 1; data_write = 1; end
                endcase
                data_addr = $urandom();
                data_wdata = $urandom();
                data_strb = 4'($urandom());
            end
            inst_ack = 1'($urandom());
            data_rack = 1'($urandom());
            mem_req_ack = 1'($urandom());
            mem_rvalid = 1'($urandom());
            mem_rdata = $urandom();
        end
        tick();
        rst = 0;
        clear_inputs();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
